scr1_dmem_router: RTL and testbench
===================================

SCR1_DMEM_ROUTER -- requirements
Module: scr1_dmem_router

Interface
REQ-001 Parameter SCR1_PORT0_ADDR_MASK, default 32'hFFFF_0000, address bits compared for port 0 selection.
REQ-002 Parameter SCR1_PORT0_ADDR_PATTERN, default 32'h0048_0000, value the masked address must equal to select port 0.
REQ-003 Reset is asynchronous and active-high; one clock.
REQ-004 clk  in  1  block clock, rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 dmem_req_i  in  1  core-side request (from LSU).
REQ-007 dmem_cmd_i  in  type_scr1_mem_cmd_e  read/write.
REQ-008 dmem_width_i  in  type_scr1_mem_width_e  byte/hword/word.
REQ-009 dmem_addr_i  in  SCR1_DMEM_AWIDTH  request address.
REQ-010 dmem_wdata_i  in  SCR1_DMEM_DWIDTH  write data.
REQ-011 dmem_req_ack_o  out  1  request accepted.
REQ-012 dmem_rdata_o  out  SCR1_DMEM_DWIDTH  read data.
REQ-013 dmem_resp_o  out  type_scr1_mem_resp_e  NOTRDY/RDY_OK/RDY_ER.
REQ-014 port0_req_o, port0_cmd_o, port0_width_o, port0_addr_o, port0_wdata_o  out  as core side  port 0 request bundle.
REQ-015 port0_req_ack_i  in  1; port0_rdata_i  in  DWIDTH; port0_resp_i  in  type_scr1_mem_resp_e  port 0 return bundle.
REQ-016 port1_* SHALL mirror REQ-014/015 for port 1 (default port).

Function
REQ-017 Port select (combinational) SHALL be port 0 iff (dmem_addr_i & MASK) == PATTERN, else port 1.
REQ-018 FSM states SHALL be IDLE and WAIT; registered port_sel_ff records the port owning the outstanding transaction.
REQ-019 cmd, width, addr, wdata SHALL be driven unmodified to both ports every cycle.
REQ-020 In IDLE: selected port req = dmem_req_i, other port req = 0; dmem_req_ack_o = selected port's req_ack_i.
REQ-021 IDLE -> WAIT when dmem_req_i & selected ack; port_sel_ff captures selection in the same edge.
REQ-022 In WAIT: dmem_resp_o and dmem_rdata_o SHALL follow port_sel_ff's port combinationally (zero added latency).
REQ-023 In WAIT with resp NOTRDY: both port reqs 0, dmem_req_ack_o = 0, state holds.
REQ-024 In WAIT with resp RDY_OK or RDY_ER: a new dmem_req_i SHALL be forwarded as in REQ-020 in the same cycle; if acked, stay WAIT with new port_sel_ff, else -> IDLE.
REQ-025 In IDLE dmem_resp_o SHALL be NOTRDY and dmem_rdata_o SHALL be 0.
REQ-026 Responses from the non-owning port SHALL be ignored in every state.
REQ-027 RDY_ER from the owning port SHALL be forwarded unchanged; the router generates no errors itself.
REQ-028 At most one transaction SHALL be outstanding at any time.

Reset
REQ-029 On rst assertion, state SHALL become IDLE and port_sel_ff port 1 asynchronously; an in-flight transaction is abandoned, late responses ignored per REQ-025/026.
REQ-030 Post-reset outputs: dmem_resp_o NOTRDY, dmem_rdata_o 0, port reqs follow REQ-020.

Structure
REQ-031 FSM state enum and port-id enum (PORT0, PORT1) SHALL be local types; mem cmd/width/resp enums SHALL come from the shared memif package.
REQ-032 Single flat module, no sub-modules.
REQ-033 Simulation assertions: no X on control inputs out of reset; no non-NOTRDY resp accepted in IDLE.

Verification
REQ-034 Read 0x0048_0010, port0 acks cycle 0, RDY_OK rdata 0xA5A5_A5A5 cycle 2 -> port1_req 0 throughout, dmem_resp RDY_OK with 0xA5A5_A5A5 in cycle 2, state IDLE cycle 3.
REQ-035 Write 0x0000_1000, port1 ack delayed 3 cycles -> port1_req held 4 cycles, dmem_req_ack 1 only in 4th, port0_req never 1.
REQ-036 Port0 read outstanding, port1 returns spurious RDY_ER -> dmem_resp stays NOTRDY until port0 responds.
REQ-037 Port0 RDY_OK in same cycle as new request to 0x2000 acked by port1 -> state WAIT, port_sel_ff port 1, next response taken from port 1.
REQ-038 Port1 returns RDY_ER -> dmem_resp RDY_ER same cycle, FSM IDLE next cycle.
REQ-039 rst pulsed during WAIT -> IDLE immediately, later port response ignored, next request routes normally.

Source files
------------

// File: rtl/scr1_dmem_router_pkg.sv
// Shared memory-interface types and widths used by the data-memory router and its neighbours.
// Command, width and response encodings match the core's LSU bus.
package scr1_dmem_router_pkg;

   localparam int SCR1_DMEM_AWIDTH = 32;
   localparam int SCR1_DMEM_DWIDTH = 32;

   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'b00,
      SCR1_MEM_WIDTH_HWORD = 2'b01,
      SCR1_MEM_WIDTH_WORD  = 2'b10,
      SCR1_MEM_WIDTH_ERROR = 2'b11
   } type_scr1_mem_width_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;

endpackage

// File: rtl/scr1_dmem_router.sv
// Routes core data-memory requests to port 0 (address window match) or port 1 (default),
// keeping one transaction outstanding and returning the owning port's response.
module scr1_dmem_router
   import scr1_dmem_router_pkg::*;
#(
   parameter logic [SCR1_DMEM_AWIDTH-1:0] SCR1_PORT0_ADDR_MASK    = 32'hFFFF_0000,
   parameter logic [SCR1_DMEM_AWIDTH-1:0] SCR1_PORT0_ADDR_PATTERN = 32'h0048_0000
)(
   input  logic                         clk,
   input  logic                         rst,

   input  logic                         dmem_req_i,
   input  type_scr1_mem_cmd_e           dmem_cmd_i,
   input  type_scr1_mem_width_e         dmem_width_i,
   input  logic [SCR1_DMEM_AWIDTH-1:0]  dmem_addr_i,
   input  logic [SCR1_DMEM_DWIDTH-1:0]  dmem_wdata_i,
   output logic                         dmem_req_ack_o,
   output logic [SCR1_DMEM_DWIDTH-1:0]  dmem_rdata_o,
   output type_scr1_mem_resp_e          dmem_resp_o,

   output logic                         port0_req_o,
   output type_scr1_mem_cmd_e           port0_cmd_o,
   output type_scr1_mem_width_e         port0_width_o,
   output logic [SCR1_DMEM_AWIDTH-1:0]  port0_addr_o,
   output logic [SCR1_DMEM_DWIDTH-1:0]  port0_wdata_o,
   input  logic                         port0_req_ack_i,
   input  logic [SCR1_DMEM_DWIDTH-1:0]  port0_rdata_i,
   input  type_scr1_mem_resp_e          port0_resp_i,

   output logic                         port1_req_o,
   output type_scr1_mem_cmd_e           port1_cmd_o,
   output type_scr1_mem_width_e         port1_width_o,
   output logic [SCR1_DMEM_AWIDTH-1:0]  port1_addr_o,
   output logic [SCR1_DMEM_DWIDTH-1:0]  port1_wdata_o,
   input  logic                         port1_req_ack_i,
   input  logic [SCR1_DMEM_DWIDTH-1:0]  port1_rdata_i,
   input  type_scr1_mem_resp_e          port1_resp_i
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_e;

   state_e                       r_state;
   state_e                       w_next_state;
   port_e                        r_port_sel;
   port_e                        w_next_port_sel;
   port_e                        w_sel;
   logic                         w_sel_ack;
   logic                         w_fwd;
   type_scr1_mem_resp_e          w_own_resp;
   logic [SCR1_DMEM_DWIDTH-1:0]  w_own_rdata;

   assign w_sel       = ((dmem_addr_i & SCR1_PORT0_ADDR_MASK) == SCR1_PORT0_ADDR_PATTERN) ? PORT0 : PORT1;
   assign w_sel_ack   = (w_sel == PORT0) ? port0_req_ack_i : port1_req_ack_i;
   assign w_own_resp  = (r_port_sel == PORT0) ? port0_resp_i  : port1_resp_i;
   assign w_own_rdata = (r_port_sel == PORT0) ? port0_rdata_i : port1_rdata_i;

   assign port0_cmd_o   = dmem_cmd_i;
   assign port0_width_o = dmem_width_i;
   assign port0_addr_o  = dmem_addr_i;
   assign port0_wdata_o = dmem_wdata_i;
   assign port1_cmd_o   = dmem_cmd_i;
   assign port1_width_o = dmem_width_i;
   assign port1_addr_o  = dmem_addr_i;
   assign port1_wdata_o = dmem_wdata_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_port_sel <= PORT1;
      end else begin
         r_state    <= w_next_state;
         r_port_sel <= w_next_port_sel;
      end
   end

   // A completing response frees the bus in the same cycle, so a back-to-back request is forwarded immediately.
   always_comb begin
      w_next_state    = r_state;
      w_next_port_sel = r_port_sel;
      w_fwd           = 1'b0;
      port0_req_o     = 1'b0;
      port1_req_o     = 1'b0;
      dmem_req_ack_o  = 1'b0;
      dmem_resp_o     = SCR1_MEM_RESP_NOTRDY;
      dmem_rdata_o    = '0;

      case (r_state)
         ST_IDLE: begin
            w_fwd = 1'b1;
         end
         ST_WAIT: begin
            dmem_resp_o  = w_own_resp;
            dmem_rdata_o = w_own_rdata;
            w_fwd        = (w_own_resp != SCR1_MEM_RESP_NOTRDY);
         end
         default: begin
            w_fwd = 1'b1;
         end
      endcase

      if (w_fwd) begin
         if (w_sel == PORT0) begin
            port0_req_o = dmem_req_i;
         end else begin
            port1_req_o = dmem_req_i;
         end
         dmem_req_ack_o = w_sel_ack;
         if (dmem_req_i && w_sel_ack) begin
            w_next_state    = ST_WAIT;
            w_next_port_sel = w_sel;
         end else begin
            w_next_state = ST_IDLE;
         end
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         assert (!$isunknown(dmem_req_i));
         if (r_state == ST_WAIT) begin
            assert (!$isunknown(w_own_resp));
         end
         if (r_state == ST_IDLE) begin
            assert (dmem_resp_o == SCR1_MEM_RESP_NOTRDY);
         end
      end
   end

endmodule

// File: tb/tb_scr1_dmem_router.sv
// Randomised and directed bench for scr1_dmem_router, checked against a transaction-owner model.
module tb_scr1_dmem_router;
   import scr1_dmem_router_pkg::*;

   localparam logic [31:0] MASK    = 32'hFFFF_0000;
   localparam logic [31:0] PATTERN = 32'h0048_0000;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 req = 1'b0;
   type_scr1_mem_cmd_e   cmd = SCR1_MEM_CMD_RD;
   type_scr1_mem_width_e width = SCR1_MEM_WIDTH_WORD;
   logic [31:0]          addr = '0;
   logic [31:0]          wdata = '0;
   logic                 p0Ack = 1'b0;
   logic [31:0]          p0Rdata = '0;
   type_scr1_mem_resp_e  p0Resp = SCR1_MEM_RESP_NOTRDY;
   logic                 p1Ack = 1'b0;
   logic [31:0]          p1Rdata = '0;
   type_scr1_mem_resp_e  p1Resp = SCR1_MEM_RESP_NOTRDY;

   logic                 dmemAck;
   logic [31:0]          dmemRdata;
   type_scr1_mem_resp_e  dmemResp;
   logic                 p0Req, p1Req;
   type_scr1_mem_cmd_e   p0Cmd, p1Cmd;
   type_scr1_mem_width_e p0Width, p1Width;
   logic [31:0]          p0Addr, p1Addr, p0Wdata, p1Wdata;

   int tests = 0;
   int failures = 0;
   // Model state: which port owns the outstanding transaction (2 = none).
   int mOwner = 2;
   int mNext = 2;

   scr1_dmem_router #(
      .SCR1_PORT0_ADDR_MASK(MASK),
      .SCR1_PORT0_ADDR_PATTERN(PATTERN)
   ) dut (
      .clk(clk), .rst(rst),
      .dmem_req_i(req), .dmem_cmd_i(cmd), .dmem_width_i(width),
      .dmem_addr_i(addr), .dmem_wdata_i(wdata),
      .dmem_req_ack_o(dmemAck), .dmem_rdata_o(dmemRdata), .dmem_resp_o(dmemResp),
      .port0_req_o(p0Req), .port0_cmd_o(p0Cmd), .port0_width_o(p0Width),
      .port0_addr_o(p0Addr), .port0_wdata_o(p0Wdata),
      .port0_req_ack_i(p0Ack), .port0_rdata_i(p0Rdata), .port0_resp_i(p0Resp),
      .port1_req_o(p1Req), .port1_cmd_o(p1Cmd), .port1_width_o(p1Width),
      .port1_addr_o(p1Addr), .port1_wdata_o(p1Wdata),
      .port1_req_ack_i(p1Ack), .port1_rdata_i(p1Rdata), .port1_resp_i(p1Resp)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Owner model: no owner forwards freely; an owner forwards only when it has answered.
   task automatic modelCompare();
      int sel;
      logic fwd, selAck;
      logic [1:0] expResp;
      logic [31:0] expRdata;
      sel = ((addr & MASK) == PATTERN) ? 0 : 1;
      selAck = (sel == 0) ? p0Ack : p1Ack;
      if (mOwner == 0) begin
         expResp = p0Resp; expRdata = p0Rdata;
      end else if (mOwner == 1) begin
         expResp = p1Resp; expRdata = p1Rdata;
      end else begin
         expResp = 2'b00; expRdata = 32'h0;
      end
      fwd = (mOwner == 2) || (expResp != 2'b00);
      checkOutput("resp", 64'(dmemResp), 64'(expResp));
      checkOutput("rdata", 64'(dmemRdata), 64'(expRdata));
      checkOutput("port0_req", 64'(p0Req), 64'(fwd && sel == 0 && req));
      checkOutput("port1_req", 64'(p1Req), 64'(fwd && sel == 1 && req));
      checkOutput("req_ack", 64'(dmemAck), 64'(fwd && selAck));
      checkOutput("port0_bus", {p0Cmd, p0Width, p0Addr, p0Wdata[28:0]}, {cmd, width, addr, wdata[28:0]});
      checkOutput("port1_bus", {p1Cmd, p1Width, p1Addr, p1Wdata[28:0]}, {cmd, width, addr, wdata[28:0]});
      checkOutput("wdata_hi", 64'({p0Wdata[31:29], p1Wdata[31:29]}), 64'({wdata[31:29], wdata[31:29]}));
      if (fwd) mNext = (req && selAck) ? sel : 2;
      else     mNext = mOwner;
   endtask

   task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr,
                                input logic iP0Ack, input logic [1:0] iP0Resp, input logic [31:0] iP0Rdata,
                                input logic iP1Ack, input logic [1:0] iP1Resp, input logic [31:0] iP1Rdata);
      @(negedge clk);
      req = iReq; addr = iAddr;
      p0Ack = iP0Ack; p0Resp = type_scr1_mem_resp_e'(iP0Resp); p0Rdata = iP0Rdata;
      p1Ack = iP1Ack; p1Resp = type_scr1_mem_resp_e'(iP1Resp); p1Rdata = iP1Rdata;
      #1;
      modelCompare();
   endtask

   task automatic advance();
      @(posedge clk);
      mOwner = mNext;
   endtask

   task automatic doReset();
      @(negedge clk);
      req = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("reset_resp", 64'(dmemResp), 64'(SCR1_MEM_RESP_NOTRDY));
      checkOutput("reset_rdata", 64'(dmemRdata), 64'h0);
      mOwner = 2;
      #2;
      rst = 1'b0;
   endtask

   localparam logic [1:0] NR = 2'b00;
   localparam logic [1:0] OK = 2'b01;
   localparam logic [1:0] ER = 2'b10;

   initial begin
      logic [31:0] a;
      logic [1:0] r0, r1;
      int k;

      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("por_resp", 64'(dmemResp), 64'(SCR1_MEM_RESP_NOTRDY));
      checkOutput("por_rdata", 64'(dmemRdata), 64'h0);
      checkOutput("por_reqs", 64'({p0Req, p1Req}), 64'h0);
      rst = 1'b0;

      // Port 0 read completing two cycles after acceptance.
      cmd = SCR1_MEM_CMD_RD;
      applyStimulus(1, 32'h0048_0010, 1, NR, 0, 0, NR, 0);
      checkOutput("d34_p0req", 64'(p0Req), 64'h1);
      checkOutput("d34_ack", 64'(dmemAck), 64'h1);
      advance();
      applyStimulus(0, 32'h0048_0010, 0, NR, 0, 0, NR, 0);
      checkOutput("d34_c1_resp", 64'(dmemResp), 64'(SCR1_MEM_RESP_NOTRDY));
      advance();
      applyStimulus(0, 32'h0048_0010, 0, OK, 32'hA5A5_A5A5, 0, NR, 0);
      checkOutput("d34_c2_resp", 64'(dmemResp), 64'(SCR1_MEM_RESP_RDY_OK));
      checkOutput("d34_c2_rdata", 64'(dmemRdata), 64'hA5A5_A5A5);
      checkOutput("d34_p1req", 64'(p1Req), 64'h0);
      advance();
      applyStimulus(0, 32'h0048_0010, 0, OK, 32'hA5A5_A5A5, 0, NR, 0);
      checkOutput("d34_c3_idle", 64'(dmemResp), 64'(SCR1_MEM_RESP_NOTRDY));
      advance();

      // Port 1 write with a late acknowledge, then an error response.
      cmd = SCR1_MEM_CMD_WR; wdata = 32'h1357_9BDF;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 32'h0000_1000, 0, NR, 0, (i == 3), NR, 0);
         checkOutput("d35_p1req", 64'(p1Req), 64'h1);
         checkOutput("d35_p0req", 64'(p0Req), 64'h0);
         checkOutput("d35_ack", 64'(dmemAck), 64'(i == 3));
         advance();
      end
      applyStimulus(0, 32'h0000_1000, 0, OK, 32'h5555_0000, 0, ER, 32'h0BAD_0BAD);
      checkOutput("d38_resp", 64'(dmemResp), 64'(SCR1_MEM_RESP_RDY_ER));
      advance();
      applyStimulus(0, 32'h0000_1000, 0, NR, 0, 0, ER, 0);
      checkOutput("d38_idle", 64'(dmemResp), 64'(SCR1_MEM_RESP_NOTRDY));
      advance();

      // Spurious port 1 error while port 0 owns, then back-to-back handover to port 1.
      cmd = SCR1_MEM_CMD_RD;
      applyStimulus(1, 32'h0048_0100, 1, NR, 0, 0, NR, 0);
      advance();
      applyStimulus(0, 32'h0048_0100, 0, NR, 0, 0, ER, 32'hDEAD_BEEF);
      checkOutput("d36_resp", 64'(dmemResp), 64'(SCR1_MEM_RESP_NOTRDY));
      advance();
      applyStimulus(1, 32'h0000_2000, 0, OK, 32'h1111_2222, 1, NR, 0);
      checkOutput("d37_resp", 64'(dmemResp), 64'(SCR1_MEM_RESP_RDY_OK));
      checkOutput("d37_p1req", 64'(p1Req), 64'h1);
      checkOutput("d37_ack", 64'(dmemAck), 64'h1);
      advance();
      applyStimulus(0, 32'h0000_2000, 0, ER, 32'hDEAD_0000, 0, OK, 32'h0000_1234);
      checkOutput("d37_owner_resp", 64'(dmemResp), 64'(SCR1_MEM_RESP_RDY_OK));
      checkOutput("d37_owner_rdata", 64'(dmemRdata), 64'h0000_1234);
      advance();

      // Reset during an outstanding port 0 read.
      applyStimulus(1, 32'h0048_0200, 1, NR, 0, 0, NR, 0);
      advance();
      doReset();
      applyStimulus(0, 32'h0048_0200, 0, OK, 32'hCAFE_F00D, 0, NR, 0);
      checkOutput("d39_late_resp", 64'(dmemResp), 64'(SCR1_MEM_RESP_NOTRDY));
      advance();
      applyStimulus(1, 32'h0000_3000, 0, NR, 0, 1, NR, 0);
      checkOutput("d39_p1req", 64'(p1Req), 64'h1);
      advance();
      applyStimulus(0, 32'h0000_3000, 0, NR, 0, 0, OK, 32'h0000_3000);
      checkOutput("d39_resp", 64'(dmemResp), 64'(SCR1_MEM_RESP_RDY_OK));
      advance();

      // Randomised traffic with occasional resets.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(99) == 0) doReset();
         k = $urandom_range(2);
         a = $urandom;
         if (k == 0)      a[31:16] = 16'h0048;
         else if (k == 1) a[31:16] = 16'h0049;
         k = $urandom_range(4);
         r0 = (k < 3) ? NR : ((k == 3) ? OK : ER);
         k = $urandom_range(4);
         r1 = (k < 3) ? NR : ((k == 3) ? OK : ER);
         cmd   = type_scr1_mem_cmd_e'($urandom_range(1));
         width = type_scr1_mem_width_e'($urandom_range(2));
         wdata = $urandom;
         applyStimulus($urandom_range(1), a, $urandom_range(1), r0, $urandom,
                       $urandom_range(1), r1, $urandom);
         advance();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
